unidade_load_store: RTL and testbench

//  Load/store unit between the MEM-stage control and the word-addressed data memory (sync write, comb read).

---
 rtl/unidade_load_store_pkg.sv | 14 +
 rtl/unidade_load_store_if.sv | 16 +
 rtl/unidade_load_store_alinhador.sv | 25 ++
 rtl/unidade_load_store.sv | 95 +++++++++
 tb/tb_unidade_load_store.sv | 161 ++++++++++++++++
 5 files changed

// File: rtl/unidade_load_store_pkg.sv
// pkg_load_store: access-size encodings, FSM states and lane helpers for the load/store unit
package pkg_load_store;
  typedef enum logic [1:0] {
    TIPO_WORD   = 2'b00,
    TIPO_HALF   = 2'b01,
    TIPO_BYTE   = 2'b10,
    TIPO_ILEGAL = 2'b11
  } tipo_t;
  typedef enum logic [1:0] {OCIOSO, LEITURA, ESCRITA, CONCLUI} estado_t;
  localparam int LARG_LANE = 8;
  function automatic logic [4:0] desl_lane(input logic [1:0] lane);
    return 5'(lane * LARG_LANE);
  endfunction
endpackage

// File: rtl/unidade_load_store_if.sv
// unidade_load_store_if: CPU request/response and data-memory port of the load/store unit
interface unidade_load_store_if #(parameter int LARG_END = 26);
  logic inicio, memRead, memWrite, sem_sinal, ocupado, pronto, erro, mem_memWrite;
  logic [1:0] tipo;
  logic [27:0] endereco_byte;
  logic [31:0] dado_cpu, dado_Lido_cpu, mem_dado_Escrito, mem_dado_Lido;
  logic [LARG_END-1:0] mem_endereco;
  modport slave (
    input  inicio, memRead, memWrite, tipo, sem_sinal, endereco_byte, dado_cpu, mem_dado_Lido,
    output ocupado, pronto, erro, dado_Lido_cpu, mem_endereco, mem_memWrite, mem_dado_Escrito
  );
  modport master (
    output inicio, memRead, memWrite, tipo, sem_sinal, endereco_byte, dado_cpu, mem_dado_Lido,
    input  ocupado, pronto, erro, dado_Lido_cpu, mem_endereco, mem_memWrite, mem_dado_Escrito
  );
endinterface

// File: rtl/unidade_load_store_alinhador.sv
// alinhador_dados: merges store lanes into a word and extracts/extends load lanes
module alinhador_dados
  import pkg_load_store::*;
(
  input  tipo_t       tipo_i,
  input  logic [1:0]  lane_i,
  input  logic        sem_sinal_i,
  input  logic [31:0] palavra_i,
  input  logic [31:0] dado_cpu_i,
  output logic [31:0] palavra_escrita_o,
  output logic [31:0] dado_lido_o
);
  logic [4:0] desl;
  logic [31:0] mascara, bruto;
  always_comb begin
    desl = desl_lane(lane_i);
    mascara = (tipo_i == TIPO_HALF ? 32'h0000_FFFF : 32'h0000_00FF) << desl;
    bruto = palavra_i >> desl;
    palavra_escrita_o = tipo_i == TIPO_WORD ? dado_cpu_i
                      : (palavra_i & ~mascara) | ((dado_cpu_i << desl) & mascara);
    dado_lido_o = tipo_i == TIPO_WORD ? palavra_i
                : tipo_i == TIPO_HALF ? {{16{~sem_sinal_i & bruto[15]}}, bruto[15:0]}
                : {{24{~sem_sinal_i & bruto[7]}}, bruto[7:0]};
  end
endmodule

// File: rtl/unidade_load_store.sv
// unidade_load_store: byte-addressed load/store unit, sub-word stores by read-modify-write.
// LSU_ALIGN_CHECK_EN: misaligned word/half accesses fault instead of being force-aligned.
module unidade_load_store
  import pkg_load_store::*;
#(
  parameter int PROFUNDIDADE = 51,
  parameter int LARG_END = 26
) (
  input logic clock,
  input logic reset,
  unidade_load_store_if.slave bus
);
  estado_t estado_q;
  tipo_t tipo_q, tipo_in;
  logic [1:0] lane_q;
  logic leitura_q, sem_q, pronto_q, erro_q, mem_we_q, falha;
  logic [31:0] dado_q, palavra_q, lido_q, palavra_escrita, dado_lido, palavra_sel;
  logic [LARG_END-1:0] mem_end_q;
  logic [27:0] end_al;
  always_comb begin
    tipo_in = tipo_t'(bus.tipo);
    end_al = tipo_in == TIPO_WORD ? {bus.endereco_byte[27:2], 2'b00}
           : tipo_in == TIPO_HALF ? {bus.endereco_byte[27:1], 1'b0} : bus.endereco_byte;
    falha = bus.memRead == bus.memWrite || tipo_in == TIPO_ILEGAL
         || 32'(bus.endereco_byte[27:2]) >= PROFUNDIDADE;
`ifdef LSU_ALIGN_CHECK_EN
    falha = falha || end_al != bus.endereco_byte;
`endif
    palavra_sel = estado_q == LEITURA ? bus.mem_dado_Lido : palavra_q;
  end
  alinhador_dados u_alinhador (
    .tipo_i           (tipo_q),
    .lane_i           (lane_q),
    .sem_sinal_i      (sem_q),
    .palavra_i        (palavra_sel),
    .dado_cpu_i       (dado_q),
    .palavra_escrita_o(palavra_escrita),
    .dado_lido_o      (dado_lido)
  );
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      estado_q  <= OCIOSO;
      tipo_q    <= TIPO_WORD;
      lane_q    <= '0;
      leitura_q <= 1'b0;
      sem_q     <= 1'b0;
      dado_q    <= '0;
      palavra_q <= '0;
      lido_q    <= '0;
      pronto_q  <= 1'b0;
      erro_q    <= 1'b0;
      mem_we_q  <= 1'b0;
      mem_end_q <= '0;
    end else begin
      pronto_q <= 1'b0;
      mem_we_q <= 1'b0;
      case (estado_q)
        OCIOSO: if (bus.inicio) begin
          tipo_q    <= tipo_in;
          lane_q    <= end_al[1:0];
          leitura_q <= bus.memRead;
          sem_q     <= bus.sem_sinal;
          dado_q    <= bus.dado_cpu;
          erro_q    <= falha;
          pronto_q  <= falha;
          mem_end_q <= falha ? mem_end_q : LARG_END'(end_al[27:2]);
          mem_we_q  <= !falha && bus.memWrite && tipo_in == TIPO_WORD;
          estado_q  <= falha ? CONCLUI
                     : (bus.memRead || tipo_in != TIPO_WORD) ? LEITURA : ESCRITA;
        end
        LEITURA: begin
          palavra_q <= bus.mem_dado_Lido;
          lido_q    <= leitura_q ? dado_lido : lido_q;
          pronto_q  <= leitura_q;
          mem_we_q  <= !leitura_q;
          estado_q  <= leitura_q ? CONCLUI : ESCRITA;
        end
        ESCRITA: begin
          pronto_q <= 1'b1;
          estado_q <= CONCLUI;
        end
        default: begin
          erro_q   <= 1'b0;
          estado_q <= OCIOSO;
        end
      endcase
    end
  assign bus.ocupado          = estado_q != OCIOSO;
  assign bus.pronto           = pronto_q;
  assign bus.erro             = erro_q;
  assign bus.dado_Lido_cpu    = lido_q;
  assign bus.mem_endereco     = mem_end_q;
  assign bus.mem_memWrite     = mem_we_q;
  assign bus.mem_dado_Escrito = mem_we_q ? palavra_escrita : '0;
endmodule

// File: tb/tb_unidade_load_store.sv
// tb_unidade_load_store: random load/store traffic against a word-array reference model
module tb_unidade_load_store;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;
  unidade_load_store_if bus ();
  unidade_load_store dut (.clock(clk), .reset(rst_n), .bus(bus));
  logic [31:0] dmem [0:63];
  logic [31:0] model [0:63];
  logic tb_we = 1'b0;
  logic [5:0] tb_a = '0;
  logic [31:0] tb_d = '0;
  int wr_count = 0;
  int pass_n = 0;
  int tot_n = 0;
  logic [31:0] lido_m = '0;
  assign bus.mem_dado_Lido = bus.mem_endereco < 26'd64 ? dmem[bus.mem_endereco[5:0]] : 32'h0;
  always @(posedge clk)
    if (tb_we) dmem[tb_a] <= tb_d;
    else if (bus.mem_memWrite) begin
      dmem[bus.mem_endereco[5:0]] <= bus.mem_dado_Escrito;
      wr_count <= wr_count + 1;
    end
  task automatic chk(input string nome, input logic [31:0] got, input logic [31:0] exp);
    tot_n++;
    if (got === exp) pass_n++;
    else $display("FAIL %s got=%h exp=%h", nome, got, exp);
  endtask
  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] l,
                                           input logic [1:0] tp, input logic s);
    logic [31:0] v;
    if (tp == 2'd0) return w;
    if (tp == 2'd1) begin
      v = {16'h0, w[l[1]*16 +: 16]};
      if (!s && v[15]) v[31:16] = 16'hFFFF;
    end else begin
      v = {24'h0, w[l*8 +: 8]};
      if (!s && v[7]) v[31:8] = 24'hFFFFFF;
    end
    return v;
  endfunction
  function automatic logic [31:0] ref_store(input logic [31:0] w, input logic [1:0] l,
                                            input logic [1:0] tp, input logic [31:0] d);
    logic [31:0] r;
    r = w;
    if (tp == 2'd0) r = d;
    else if (tp == 2'd1) r[l[1]*16 +: 16] = d[15:0];
    else r[l*8 +: 8] = d[7:0];
    return r;
  endfunction
  task automatic op(input logic rd, input logic wr, input logic [1:0] tp, input logic sem,
                    input logic [27:0] a, input logic [31:0] d, input logic intrude);
    logic falha;
    logic [27:0] ea;
    int w, lat, n, w0;
    ea = tp == 2'd0 ? {a[27:2], 2'b00} : tp == 2'd1 ? {a[27:1], 1'b0} : a;
    w = int'(a[27:2]);
    falha = (rd == wr) || tp == 2'b11 || w >= 51;
`ifdef LSU_ALIGN_CHECK_EN
    falha = falha || ea != a;
`endif
    lat = falha ? 1 : (wr && tp != 2'd0) ? 3 : 2;
    if (!falha && rd) lido_m = ref_load(model[w], ea[1:0], tp, sem);
    if (!falha && wr) model[w] = ref_store(model[w], ea[1:0], tp, d);
    w0 = wr_count;
    @(negedge clk);
    bus.memRead = rd; bus.memWrite = wr; bus.tipo = tp; bus.sem_sinal = sem;
    bus.endereco_byte = a; bus.dado_cpu = d; bus.inicio = 1'b1;
    @(posedge clk); #1;
    bus.inicio = 1'b0; bus.dado_cpu = $urandom; bus.endereco_byte = 28'($urandom);
    bus.sem_sinal = ~sem; bus.tipo = ~tp;
    n = 0;
    while (!bus.pronto && n < 8) begin
      if (intrude && n == 0) begin
        bus.memWrite = 1'b1; bus.memRead = 1'b0; bus.tipo = 2'd0;
        bus.endereco_byte = 28'h0; bus.dado_cpu = 32'hBAD0BAD0; bus.inicio = 1'b1;
      end
      @(posedge clk); #1;
      bus.inicio = 1'b0;
      n++;
    end
    chk("latencia", 32'(n + 1), 32'(lat));
    chk("erro", {31'b0, bus.erro}, {31'b0, falha});
    chk("ocupado_fim", {31'b0, bus.ocupado}, 32'd1);
    chk("dado_lido", bus.dado_Lido_cpu, lido_m);
    @(posedge clk); #1;
    chk("escritas", 32'(wr_count - w0), (!falha && wr) ? 32'd1 : 32'd0);
    chk("pronto_pulso", {31'b0, bus.pronto}, 32'd0);
    chk("ocioso", {31'b0, bus.ocupado}, 32'd0);
    if (w < 51) chk("palavra", dmem[w], model[w]);
    if (intrude) chk("intruso", dmem[0], model[0]);
  endtask
  initial begin
    logic [31:0] v;
    int r;
    bus.inicio = 1'b0; bus.memRead = 1'b0; bus.memWrite = 1'b0; bus.tipo = 2'd0;
    bus.sem_sinal = 1'b0; bus.endereco_byte = '0; bus.dado_cpu = '0;
    #1 rst_n = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      v = $urandom;
      tb_we = 1'b1; tb_a = 6'(i); tb_d = v; model[i] = v;
    end
    @(negedge clk);
    tb_we = 1'b0;
    chk("rst_ocupado", {31'b0, bus.ocupado}, 32'd0);
    chk("rst_pronto", {31'b0, bus.pronto}, 32'd0);
    chk("rst_erro", {31'b0, bus.erro}, 32'd0);
    chk("rst_lido", bus.dado_Lido_cpu, 32'd0);
    chk("rst_end", 32'(bus.mem_endereco), 32'd0);
    chk("rst_we", {31'b0, bus.mem_memWrite}, 32'd0);
    chk("rst_wdata", bus.mem_dado_Escrito, 32'd0);
    rst_n = 1'b1;
    op(1'b0, 1'b1, 2'd0, 1'b0, 28'h10, 32'hDEADBEEF, 1'b0);
    chk("sw_lit", dmem[4], 32'hDEADBEEF);
    op(1'b0, 1'b1, 2'd2, 1'b0, 28'h11, 32'h000000AA, 1'b0);
    chk("sb_lit", dmem[4], 32'hDEADAAEF);
    op(1'b1, 1'b0, 2'd2, 1'b0, 28'h13, 32'h0, 1'b0);
    chk("lb_lit", bus.dado_Lido_cpu, 32'hFFFFFFDE);
    op(1'b1, 1'b0, 2'd1, 1'b1, 28'h12, 32'h0, 1'b0);
    chk("lhu_lit", bus.dado_Lido_cpu, 32'h0000DEAD);
    op(1'b1, 1'b0, 2'd0, 1'b0, 28'd204, 32'h0, 1'b0);
    chk("lw_fora_lit", bus.dado_Lido_cpu, 32'h0000DEAD);
    op(1'b1, 1'b0, 2'd0, 1'b0, 28'h12, 32'h0, 1'b0);
`ifdef LSU_ALIGN_CHECK_EN
    chk("lw_desalinhado_lit", bus.dado_Lido_cpu, 32'h0000DEAD);
`else
    chk("lw_desalinhado_lit", bus.dado_Lido_cpu, 32'hDEADAAEF);
`endif
    op(1'b1, 1'b1, 2'd0, 1'b0, 28'h20, 32'h1, 1'b0);
    op(1'b0, 1'b0, 2'd1, 1'b0, 28'h20, 32'h1, 1'b0);
    op(1'b0, 1'b1, 2'd3, 1'b0, 28'h20, 32'h1, 1'b0);
    op(1'b0, 1'b1, 2'd1, 1'b0, 28'h1A, 32'h0000CAFE, 1'b1);
    @(negedge clk);
    bus.memRead = 1'b0; bus.memWrite = 1'b1; bus.tipo = 2'd0; bus.sem_sinal = 1'b0;
    bus.endereco_byte = 28'h1C; bus.dado_cpu = 32'h12345678; bus.inicio = 1'b1;
    @(posedge clk); #1;
    bus.inicio = 1'b0;
    chk("we_escrita", {31'b0, bus.mem_memWrite}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("we_reset", {31'b0, bus.mem_memWrite}, 32'd0);
    chk("ocupado_reset", {31'b0, bus.ocupado}, 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    lido_m = '0;
    chk("reset_sem_escrita", dmem[7], model[7]);
    chk("lido_reset", bus.dado_Lido_cpu, 32'd0);
    for (int k = 0; k < 200; k++) begin
      r = $urandom_range(0, 9);
      op(r inside {[1:4], 9}, r >= 5,
         $urandom_range(0, 7) == 7 ? 2'd3 : 2'($urandom_range(0, 2)),
         1'($urandom_range(0, 1)),
         {26'($urandom_range(0, 55)), 2'($urandom_range(0, 3))},
         $urandom, $urandom_range(0, 7) == 0);
    end
    for (int i = 0; i < 51; i++) chk("memoria_final", dmem[i], model[i]);
    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end
endmodule
